// File: rtl/operand_issue_unit_pkg.sv
// operand_issue_unit_pkg: shared widths, instruction field offsets and ALU opcodes
package operand_issue_unit_pkg;
    localparam int DW      = 4;
    localparam int NREG    = 4;
    localparam int RA      = $clog2(NREG);
    localparam int IW      = 3 + 3 * RA;
    localparam int RT_LSB  = 0;
    localparam int RS_LSB  = RA;
    localparam int RD_LSB  = 2 * RA;
    localparam int SEL_LSB = 3 * RA;
    typedef enum logic [2:0] {
        OP_SUB  = 3'd0,
        OP_ADD  = 3'd1,
        OP_OR   = 3'd2,
        OP_AND  = 3'd3,
        OP_ROTR = 3'd4,
        OP_ROTL = 3'd5,
        OP_LT   = 3'd6,
        OP_EQ   = 3'd7
    } op_e;
endpackage

// File: rtl/operand_issue_unit_issue_fifo.sv
// issue_fifo: count-based in-order instruction FIFO
//   push_i/data_i : write side, ignored while full_o
//   pop_i/data_o  : read side, data_o is the head entry, ignored while empty_o
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    // full blocks a push even if a pop frees a slot in the same cycle
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/operand_issue_unit.sv
// operand_issue_unit: buffers instructions, reads/forwards operands, drives the ALU and writes back
//   instr_valid/instr_ready/instr : instruction push (sel, rd, rs, rt)
//   run                           : enables issue from the FIFO
//   init_we/init_addr/init_data   : external register-file write
//   ex_rs/ex_rt/ex_sel/ex_valid   : execute-stage operands to the ALU
//   ex_rd                         : ALU result, written back to ex_rd_addr
//   dbg_addr/dbg_data             : raw register-file read
//   retire_cnt                    : wrapping count of written-back instructions
module operand_issue_unit
    import operand_issue_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    input  logic          run,
    input  logic          init_we,
    input  logic [RA-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    output logic [DW-1:0] ex_rs,
    output logic [DW-1:0] ex_rt,
    output logic [2:0]    ex_sel,
    output logic          ex_valid,
    input  logic [DW-1:0] ex_rd,
    input  logic [RA-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [7:0]    retire_cnt
);
    logic [IW-1:0] head;
    logic          full, empty, issue;
    logic [RA-1:0] rs_a, rt_a, rd_a;
    logic [2:0]    sel;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] op_rs, op_rt, ex_rs_q, ex_rt_q;
    logic [2:0]    ex_sel_q;
    logic [RA-1:0] ex_rd_addr_q;
    logic          ex_valid_q;
    logic [7:0]    retire_q;
    issue_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (instr_valid),
        .pop_i   (issue),
        .data_i  (instr),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign instr_ready = ~full;
    assign issue       = run & ~empty;
    assign rt_a        = head[RT_LSB +: RA];
    assign rs_a        = head[RS_LSB +: RA];
    assign rd_a        = head[RD_LSB +: RA];
    assign sel         = head[SEL_LSB +: 3];
    // the pending writeback bypasses the register file so dependents issue without a bubble
    assign op_rs       = (ex_valid_q && rs_a == ex_rd_addr_q) ? ex_rd : rf_q[rs_a];
    assign op_rt       = (ex_valid_q && rt_a == ex_rd_addr_q) ? ex_rd : rf_q[rt_a];
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_sel      = ex_sel_q;
    assign ex_valid    = ex_valid_q;
    assign dbg_data    = rf_q[dbg_addr];
    assign retire_cnt  = retire_q;
    // writeback is assigned last so it wins over an init write to the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            if (init_we) rf_q[init_addr] <= init_data;
            if (ex_valid_q) rf_q[ex_rd_addr_q] <= ex_rd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_sel_q     <= '0;
            ex_rd_addr_q <= '0;
            ex_valid_q   <= 1'b0;
            retire_q     <= '0;
        end else begin
            ex_valid_q <= issue;
            retire_q   <= retire_q + 8'(ex_valid_q);
            if (issue) begin
                ex_rs_q      <= op_rs;
                ex_rt_q      <= op_rt;
                ex_sel_q     <= sel;
                ex_rd_addr_q <= rd_a;
            end
        end
    end
endmodule
